// File: rtl/miriscv_lsu_pkg.sv
// Shared constants and types for the load/store unit.
// MIRISCV_LSU_RMW_EN selects read-modify-write sub-word stores (adds the WR state).
package miriscv_lsu_pkg;

    // funct3 access-size encodings
    localparam logic [2:0] SizeB  = 3'b000;
    localparam logic [2:0] SizeH  = 3'b001;
    localparam logic [2:0] SizeW  = 3'b010;
    localparam logic [2:0] SizeBu = 3'b100;
    localparam logic [2:0] SizeHu = 3'b101;

    // Byte-lane masks before shifting to the addressed lane
    localparam logic [3:0] MaskB = 4'b0001;
    localparam logic [3:0] MaskH = 4'b0011;
    localparam logic [3:0] MaskW = 4'b1111;

`ifdef MIRISCV_LSU_RMW_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StDone = 2'd2
    } lsu_state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDone = 2'd2
    } lsu_state_e;
`endif

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic: load extract/extend and store merge (MIRISCV_LSU_RMW_EN)
// or store replicate plus lane mask (default).
module miriscv_lsu_align
    import miriscv_lsu_pkg::*;
(
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data,
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
`ifdef MIRISCV_LSU_RMW_EN
    input  logic [31:0] st_base,
    output logic [31:0] st_word
`else
    output logic [31:0] st_word,
    output logic [3:0]  st_mask
`endif
);

    logic [31:0] ld_shift;
    logic [31:0] st_repl;
    logic [3:0]  lane_mask;

    // Halfwords are aligned, so shifting by the byte lane also lands them at bit 0
    assign ld_shift = ld_word >> {ld_lane, 3'b000};

    // Extract and extend; funct3[2] selects zero extension
    always_comb begin
        case (ld_size[1:0])
            2'b00:   ld_data = {{24{~ld_size[2] & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = {{16{~ld_size[2] & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    // Replicate store data across lanes and build the addressed lane mask
    always_comb begin
        case (st_size)
            2'b00: begin
                st_repl   = {4{st_data[7:0]}};
                lane_mask = MaskB << st_lane;
            end
            2'b01: begin
                st_repl   = {2{st_data[15:0]}};
                lane_mask = MaskH << st_lane;
            end
            default: begin
                st_repl   = st_data;
                lane_mask = MaskW;
            end
        endcase
    end

`ifdef MIRISCV_LSU_RMW_EN
    // Replace only the enabled lanes of the previously read word
    always_comb begin
        st_word = st_base;
        for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) st_word[8*i +: 8] = st_repl[8*i +: 8];
        end
    end
`else
    assign st_word = st_repl;
    assign st_mask = lane_mask;
`endif

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: core request side to word-wide data memory port.
// MIRISCV_LSU_RMW_EN: sub-word stores read-modify-write via a WR state, full-word strobes.
// Default: sub-word stores write once in IDLE using byte-lane enables.
module miriscv_lsu
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MEM_AW = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_data_i,
    output logic [31:0]       lsu_data_o,
    output logic              lsu_stall_o,
    output logic              lsu_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    input  logic [31:0]       mem_rd_i
);

    lsu_state_e        state_q, state_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic              mem_we;
    logic [31:0]       mem_wd;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] addr_sel;
    logic [MEM_AW-1:0] word_idx;
    logic [31:0]       ld_data;
    logic [31:0]       st_word;
    logic              size_ok, align_ok, legal;

`ifdef MIRISCV_LSU_RMW_EN
    logic              latch_en;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    assign addr_sel = (state_q == StWr) ? addr_q : lsu_addr_i;
`else
    logic [3:0]        st_mask;

    assign addr_sel = lsu_addr_i;
`endif

    // Word index is what the memory decodes; upper bits pass through unchanged
    assign word_idx   = addr_sel[MEM_AW+1:2];
    assign mem_addr_o = {addr_sel[ADDR_W-1:MEM_AW+2], word_idx, 2'b00};

    // Size/alignment legality; stores have no unsigned variants
    always_comb begin
        size_ok  = 1'b1;
        align_ok = 1'b1;
        case (lsu_size_i)
            SizeB, SizeBu: align_ok = 1'b1;
            SizeH, SizeHu: align_ok = ~lsu_addr_i[0];
            SizeW:         align_ok = (lsu_addr_i[1:0] == 2'b00);
            default:       size_ok  = 1'b0;
        endcase
    end

    assign legal = size_ok && align_ok && !(lsu_we_i && lsu_size_i[2]);

    miriscv_lsu_align u_align (
        .ld_size (lsu_size_i),
        .ld_lane (addr_sel[1:0]),
        .ld_word (mem_rd_i),
        .ld_data (ld_data),
`ifdef MIRISCV_LSU_RMW_EN
        .st_size (size_q),
        .st_lane (addr_sel[1:0]),
        .st_data (wdata_q),
        .st_base (rdata_q),
        .st_word (st_word)
`else
        .st_size (lsu_size_i[1:0]),
        .st_lane (addr_sel[1:0]),
        .st_data (lsu_data_i),
        .st_word (st_word),
        .st_mask (st_mask)
`endif
    );

    // Next-state and memory-port decode
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        mem_wd  = '0;
        mem_be  = '0;
`ifdef MIRISCV_LSU_RMW_EN
        latch_en = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (lsu_req_i) begin
                    state_d = StDone;
                    if (!legal) begin
                        err_d = 1'b1;
                    end else if (!lsu_we_i) begin
                        data_d = ld_data;
                    end else if (lsu_size_i == SizeW) begin
                        mem_we = 1'b1;
                        mem_wd = lsu_data_i;
                        mem_be = MaskW;
                    end else begin
`ifdef MIRISCV_LSU_RMW_EN
                        latch_en = 1'b1;
                        state_d  = StWr;
`else
                        mem_we = 1'b1;
                        mem_wd = st_word;
                        mem_be = st_mask;
`endif
                    end
                end
            end
`ifdef MIRISCV_LSU_RMW_EN
            StWr: begin
                mem_we  = 1'b1;
                mem_wd  = st_word;
                mem_be  = MaskW;
                state_d = StDone;
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, load result and error pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef MIRISCV_LSU_RMW_EN
    // Capture the access and the current memory word for the write phase
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (latch_en) begin
            addr_q  <= lsu_addr_i;
            size_q  <= lsu_size_i[1:0];
            wdata_q <= lsu_data_i;
            rdata_q <= mem_rd_i;
        end
    end
`endif

    // Reset silences the write port even while the core still holds a request
    assign mem_we_o    = mem_we & rst_ni;
    assign mem_wd_o    = rst_ni ? mem_wd : '0;
    assign mem_be_o    = rst_ni ? mem_be : '0;
    assign lsu_data_o  = data_q;
    assign lsu_err_o   = err_q;
    assign lsu_stall_o = lsu_req_i && (state_q != StDone);

endmodule
